// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives PC to a combinational instruction memory and hands the latched
// word to decode over a valid/ready handshake. Handles redirect, stall, halt and address faults.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH  = 128,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] InsAddr,
  output logic        InsMemRW,
  input  logic [31:0] InsData,
  input  logic        IdReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic [31:0] IR,
  output logic [31:0] IRPC,
  output logic [31:0] PC4,
  output logic        IRValid,
  output logic        Halted,
  output logic        Fault
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STALL, S_HALT, S_FAULT} state_t;

  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_ir, w_ir_nx;
  logic [31:0] r_irpc, w_irpc_nx;
  logic [31:0] r_pc4, w_pc4_nx;
  logic        r_irvalid, w_irvalid_nx;
  logic        r_fault, w_fault_nx;
  logic [31:0] w_pc_inc;
  logic        w_slot_free;
  logic        w_halt_op;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W);
  endfunction

  assign w_pc_inc    = r_pc + 32'd4;
  assign w_slot_free = !r_irvalid || IdReady;
  assign w_halt_op   = (InsData[31:26] == HALT_OPCODE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_irpc    <= '0;
      r_pc4     <= '0;
      r_irvalid <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_ir      <= w_ir_nx;
      r_irpc    <= w_irpc_nx;
      r_pc4     <= w_pc4_nx;
      r_irvalid <= w_irvalid_nx;
      r_fault   <= w_fault_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_ir_nx      = r_ir;
    w_irpc_nx    = r_irpc;
    w_pc4_nx     = r_pc4;
    w_irvalid_nx = r_irvalid;
    w_fault_nx   = r_fault;
    case (r_state)
      S_IDLE, S_FETCH, S_STALL: begin
        if (Redirect) begin
          w_pc_nx      = RedirectAddr;
          w_irvalid_nx = 1'b0;
          if (addr_bad(RedirectAddr)) begin
            w_fault_nx = 1'b1;
            w_state_nx = S_FAULT;
          end else begin
            w_state_nx = S_FETCH;
          end
        end else if (r_state == S_IDLE) begin
          w_state_nx = S_FETCH;
        end else if (w_slot_free) begin
          // A halt word is latched normally but the PC stays on it.
          if (w_halt_op) begin
            w_ir_nx      = InsData;
            w_irpc_nx    = r_pc;
            w_pc4_nx     = w_pc_inc;
            w_irvalid_nx = 1'b1;
            w_state_nx   = S_HALT;
          end else if (addr_bad(w_pc_inc)) begin
            w_pc_nx      = w_pc_inc;
            w_irvalid_nx = 1'b0;
            w_fault_nx   = 1'b1;
            w_state_nx   = S_FAULT;
          end else begin
            w_ir_nx      = InsData;
            w_irpc_nx    = r_pc;
            w_pc4_nx     = w_pc_inc;
            w_irvalid_nx = 1'b1;
            w_pc_nx      = w_pc_inc;
            w_state_nx   = S_FETCH;
          end
        end else begin
          w_state_nx = S_STALL;
        end
      end
      S_HALT: begin
        if (IdReady) w_irvalid_nx = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign InsAddr  = r_pc;
  assign InsMemRW = (r_state == S_FETCH) || (r_state == S_STALL);
  assign IR       = r_ir;
  assign IRPC     = r_irpc;
  assign PC4      = r_pc4;
  assign IRValid  = r_irvalid;
  assign Halted   = (r_state == S_HALT);
  assign Fault    = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic, checked against
// a slot-level reference model; decode handshakes go through a scoreboard queue.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset, IdReady, Redirect;
  logic [31:0] RedirectAddr, InsAddr, InsData, IR, IRPC, PC4;
  logic        InsMemRW, IRValid, Halted, Fault;

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (128),
    .HALT_OPCODE(6'h3F)
  ) dut (
    .CLK(CLK), .Reset(Reset), .InsAddr(InsAddr), .InsMemRW(InsMemRW), .InsData(InsData),
    .IdReady(IdReady), .Redirect(Redirect), .RedirectAddr(RedirectAddr), .IR(IR), .IRPC(IRPC),
    .PC4(PC4), .IRValid(IRValid), .Halted(Halted), .Fault(Fault)
  );

  logic [31:0] mem [0:127];

  always_comb begin
    if (InsAddr[31:2] < 30'd128) InsData = mem[InsAddr[8:2]];
    else                         InsData = '0;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] irpc;
    logic [31:0] pc4;
  } xfer_t;
  xfer_t sbq[$];
  xfer_t e;

  // Reference model: one instruction slot, a PC and a coarse mode.
  localparam int BOOT = 0, RUN = 1, HLT = 2, FLT = 3;
  logic [31:0] m_pc, m_ir, m_irpc, m_pc4;
  bit          m_have, m_fault, m_known;
  int          m_mode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] < 30'd128) return mem[a[8:2]];
    return 32'h0;
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 128);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_pc(input logic [31:0] a);
    m_pc   = a;
    m_have = 0;
    if (bad(a)) begin
      m_fault = 1;
      m_mode  = FLT;
    end else begin
      m_mode = RUN;
    end
  endtask

  task automatic model_step(input bit rst, input bit redir, input logic [31:0] ra, input bit rdy);
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_ir = 0; m_irpc = 0; m_pc4 = 0;
      m_have = 0; m_fault = 0; m_mode = BOOT; m_known = 1;
    end else if (m_known) begin
      w = mem_word(m_pc);
      case (m_mode)
        BOOT: if (redir) load_pc(ra); else m_mode = RUN;
        RUN: begin
          if (redir) load_pc(ra);
          else if (!m_have || rdy) begin
            if (w[31:26] == 6'h3F) begin
              m_ir = w; m_irpc = m_pc; m_pc4 = m_pc + 4; m_have = 1; m_mode = HLT;
            end else if (bad(m_pc + 4)) begin
              m_pc = m_pc + 4; m_have = 0; m_fault = 1; m_mode = FLT;
            end else begin
              m_ir = w; m_irpc = m_pc; m_pc4 = m_pc + 4; m_have = 1; m_pc = m_pc + 4;
            end
          end
        end
        HLT: if (rdy) m_have = 0;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, check visible state, predict the handshake, advance the model.
  task automatic cycle(input bit rst, input bit redir, input logic [31:0] ra, input bit rdy);
    Reset = rst; Redirect = redir; RedirectAddr = ra; IdReady = rdy;
    #1;
    if (m_known) begin
      check("InsAddr", InsAddr, m_pc);
      check("InsMemRW", {31'b0, InsMemRW}, {31'b0, m_mode == RUN});
      check("Halted", {31'b0, Halted}, {31'b0, m_mode == HLT});
      check("Fault", {31'b0, Fault}, {31'b0, m_fault});
      check("IRValid", {31'b0, IRValid}, {31'b0, m_have});
      if (m_have || m_mode == BOOT) begin
        check("IR", IR, m_ir);
        check("IRPC", IRPC, m_irpc);
        check("PC4", PC4, m_pc4);
      end
      if (m_have && rdy && !rst) sbq.push_back('{ir: m_ir, irpc: m_irpc, pc4: m_pc4});
    end
    model_step(rst, redir, ra, rdy);
    @(posedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    if (Reset === 1'b0 && IRValid === 1'b1 && IdReady === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got IR=%h IRPC=%h expected no handshake", IR, IRPC);
      end else begin
        e = sbq.pop_front();
        check("xfer_IR", IR, e.ir);
        check("xfer_IRPC", IRPC, e.irpc);
        check("xfer_PC4", PC4, e.pc4);
      end
    end
  end

  initial begin
    int unsigned stuck;
    logic [31:0] w, ra;
    bit rst, redir;
    m_known = 0; m_mode = BOOT; m_have = 0; m_fault = 0;
    m_pc = 0; m_ir = 0; m_irpc = 0; m_pc4 = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0] = 32'h2008_0000; mem[1] = 32'h2009_0001; mem[2] = 32'h0109_502a;

    // Reset, sequential fetch, stall, redirect, misaligned redirect fault.
    repeat (2) cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h10, 0);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h12, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // Sequential run off the end of memory, and an out-of-range redirect.
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h1F0, 0);
    repeat (8) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 1, 32'h200, 1);
    repeat (2) cycle(0, 0, 0, 1);

    // Halt, ignored redirect, reset and refetch, then reset mid-stall.
    mem[3] = 32'hFC00_0000;
    cycle(1, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 0 == 1 ? 0 : 1);
    cycle(0, 1, 32'h10, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if ($urandom_range(0, 99) < 3) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      mem[i] = w;
    end
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == HLT || m_mode == FLT) stuck++;
      else stuck = 0;
      rst   = (stuck > 4) || ($urandom_range(0, 199) == 0);
      redir = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       ra = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
        1:       ra = 32'($urandom_range(128, 300)) << 2;
        2:       ra = 32'($urandom_range(120, 127)) << 2;
        default: ra = 32'($urandom_range(0, 127)) << 2;
      endcase
      if (rst) stuck = 0;
      cycle(rst, redir, ra, $urandom_range(0, 9) < 7);
    end
    cycle(0, 0, 0, 0);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL xfer_missing: got %0d pending handshakes expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
